// File: rtl/prim_ram_arb_pkg.sv
// Shared types for the arbitrated single-port RAM.
// Channel index type and wrap-around helper.
package prim_ram_arb_pkg;

  localparam int MaxCh = 8;

  typedef logic [$clog2(MaxCh)-1:0] ch_idx_t;

  function automatic ch_idx_t ch_add(
    ch_idx_t     a,
    int unsigned b,
    int unsigned n
  );
    return ch_idx_t'((32'(a) + b) % n);
  endfunction

endpackage

// File: rtl/prim_rr_arb.sv
// Round-robin arbiter; priority pointer moves
// past the last granted channel.
module prim_rr_arb
  import prim_ram_arb_pkg::*;
#(
  parameter int NumCh = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumCh-1:0] req_i,
  output logic [NumCh-1:0] gnt_o
);

  ch_idx_t          ptr_q;
  ch_idx_t          win;
  ch_idx_t          cand;
  logic             any;
  logic [MaxCh-1:0] req_ext;

  assign req_ext = MaxCh'(req_i);

  always_comb begin
    win  = ptr_q;
    cand = ptr_q;
    any  = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      cand = ch_add(ptr_q, i, NumCh);
      if (!any && req_ext[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NumCh; k++) begin
      gnt_o[k] = any && (win == ch_idx_t'(k));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= ch_add(win, 1, NumCh);
    end
  end

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Single-port RAM shared by NumCh requesters
// through a round-robin arbiter.
module prim_ram_1p_arb
  import prim_ram_arb_pkg::*;
#(
  parameter int  Width           = 32,
  parameter int  Depth           = 2048,
  parameter int  DataBitsPerMask = 8,
  parameter int  NumCh           = 2,
  parameter int  OutReg          = 0,
  localparam int Aw              = $clog2(Depth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCh-1:0]       req_i,
  output logic [NumCh-1:0]       gnt_o,
  input  logic [NumCh-1:0]       write_i,
  input  logic [NumCh*Aw-1:0]    addr_i,
  input  logic [NumCh*Width-1:0] wdata_i,
  input  logic [NumCh*Width-1:0] wmask_i,
  output logic [NumCh-1:0]       rvalid_o,
  output logic [NumCh-1:0]       rerr_o,
  output logic [Width-1:0]       rdata_o
);

  localparam int          NumMask = Width / DataBitsPerMask;
  localparam logic [Aw:0] DepthL  = (Aw+1)'(Depth);

  logic [NumCh-1:0] gnt;
  logic             sel_wr;
  logic [Aw-1:0]    sel_addr;
  logic [Width-1:0] sel_wdata;
  logic [Width-1:0] sel_wmask;
  logic [Width-1:0] bmask;
  logic             acc;
  logic             in_range;
  logic             we;
  logic             re;

  prim_rr_arb #(
    .NumCh(NumCh)
  ) u_arb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .gnt_o(gnt)
  );

  assign gnt_o = gnt;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int k = 0; k < NumCh; k++) begin
      if (gnt[k]) begin
        sel_wr    = write_i[k];
        sel_addr  = addr_i[k*Aw +: Aw];
        sel_wdata = wdata_i[k*Width +: Width];
        sel_wmask = wmask_i[k*Width +: Width];
      end
    end
  end

  // A mask group is written only if every bit of it is enabled.
  always_comb begin
    bmask = '0;
    for (int j = 0; j < NumMask; j++) begin
      bmask[j*DataBitsPerMask +: DataBitsPerMask] =
        {DataBitsPerMask{&sel_wmask[j*DataBitsPerMask +: DataBitsPerMask]}};
    end
  end

  assign acc      = |gnt & ~rst_i;
  assign in_range = {1'b0, sel_addr} < DepthL;
  assign we       = acc & sel_wr & in_range;
  assign re       = acc & ~sel_wr;

  logic [Width-1:0] mem [Depth];

  always @(posedge clk_i) begin
    if (we) begin
      mem[sel_addr] <= (mem[sel_addr] & ~bmask) | (sel_wdata & bmask);
    end
  end

  logic [NumCh-1:0] rv_q;
  logic [NumCh-1:0] err_q;
  logic [Width-1:0] rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rv_q  <= '0;
      err_q <= '0;
      rd_q  <= '0;
    end else begin
      rv_q  <= re ? gnt : '0;
      err_q <= (re && !in_range) ? gnt : '0;
      if (re) begin
        rd_q <= in_range ? mem[sel_addr] : '0;
      end
    end
  end

  if (OutReg != 0) begin : g_oreg
    logic [NumCh-1:0] rv2_q;
    logic [NumCh-1:0] err2_q;
    logic [Width-1:0] rd2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rv2_q  <= '0;
        err2_q <= '0;
        rd2_q  <= '0;
      end else begin
        rv2_q  <= rv_q;
        err2_q <= err_q;
        if (|rv_q) begin
          rd2_q <= rd_q;
        end
      end
    end

    assign rvalid_o = rv2_q;
    assign rerr_o   = err2_q;
    assign rdata_o  = rd2_q;
  end else begin : g_noreg
    assign rvalid_o = rv_q;
    assign rerr_o   = err_q;
    assign rdata_o  = rd_q;
  end

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// Random and directed checks of two RAM configs
// against a cycle-level behavioural model.
module tb_prim_ram_1p_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [1:0]  req_a, wr_a, gnt_a, rv_a, err_a;
  logic [19:0] addr_a;
  logic [63:0] wd_a, wm_a;
  logic [31:0] rd_a;

  logic [2:0]  req_b, wr_b, gnt_b, rv_b, err_b;
  logic [11:0] addr_b;
  logic [47:0] wd_b, wm_b;
  logic [15:0] rd_b;

  prim_ram_1p_arb #(
    .Width(32), .Depth(1000), .DataBitsPerMask(8),
    .NumCh(2), .OutReg(0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a),
    .write_i(wr_a), .addr_i(addr_a), .wdata_i(wd_a),
    .wmask_i(wm_a), .rvalid_o(rv_a), .rerr_o(err_a),
    .rdata_o(rd_a)
  );

  prim_ram_1p_arb #(
    .Width(16), .Depth(16), .DataBitsPerMask(8),
    .NumCh(3), .OutReg(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b),
    .write_i(wr_b), .addr_i(addr_b), .wdata_i(wd_b),
    .wmask_i(wm_b), .rvalid_o(rv_b), .rerr_o(err_b),
    .rdata_o(rd_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // per-DUT stimulus for the current cycle
  bit          s_req [2][8];
  bit          s_wr  [2][8];
  int          s_addr[2][8];
  logic [31:0] s_wd  [2][8];
  logic [31:0] s_wm  [2][8];

  // reference model state
  logic [31:0] mm    [2][1024];
  int          ptr   [2];
  logic [31:0] lastrd[2];
  bit          ev_v  [2][4];
  int          ev_ch [2][4];
  logic [31:0] ev_d  [2][4];
  bit          ev_err[2][4];

  logic [31:0] o_gnt[2], o_rv[2], o_err[2], o_rd[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        s_req[d][k]  = 1'b0;
        s_wr[d][k]   = 1'b0;
        s_addr[d][k] = 0;
        s_wd[d][k]   = '0;
        s_wm[d][k]   = '0;
      end
    end
  endtask

  task automatic set_ch(int d, int k, bit w, int a,
                        logic [31:0] wd, logic [31:0] wm);
    s_req[d][k]  = 1'b1;
    s_wr[d][k]   = w;
    s_addr[d][k] = a;
    s_wd[d][k]   = wd;
    s_wm[d][k]   = wm;
  endtask

  task automatic apply();
    logic [31:0] t;
    for (int k = 0; k < 2; k++) begin
      req_a[k] = s_req[0][k];
      wr_a[k]  = s_wr[0][k];
      addr_a[k*10 +: 10] = 10'(s_addr[0][k]);
      wd_a[k*32 +: 32]   = s_wd[0][k];
      wm_a[k*32 +: 32]   = s_wm[0][k];
    end
    for (int k = 0; k < 3; k++) begin
      req_b[k] = s_req[1][k];
      wr_b[k]  = s_wr[1][k];
      addr_b[k*4 +: 4] = 4'(s_addr[1][k]);
      t = s_wd[1][k];
      wd_b[k*16 +: 16] = t[15:0];
      t = s_wm[1][k];
      wm_b[k*16 +: 16] = t[15:0];
    end
  endtask

  task automatic cyc_check(int d);
    int nc, lat, dep, nb, gch, c, a, sl;
    logic [31:0] wmsk, og, orv, oerr, ord, eg, erv, eerr;
    nc   = (d == 0) ? 2 : 3;
    lat  = (d == 0) ? 1 : 2;
    dep  = (d == 0) ? 1000 : 16;
    nb   = (d == 0) ? 4 : 2;
    wmsk = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    og   = (d == 0) ? 32'(gnt_a) : 32'(gnt_b);
    orv  = (d == 0) ? 32'(rv_a)  : 32'(rv_b);
    oerr = (d == 0) ? 32'(err_a) : 32'(err_b);
    ord  = (d == 0) ? 32'(rd_a)  : 32'(rd_b);
    if (rst) begin
      ptr[d] = 0;
      lastrd[d] = '0;
      for (int s = 0; s < 4; s++) ev_v[d][s] = 1'b0;
    end
    gch = -1;
    for (int i = 0; i < nc; i++) begin
      c = (ptr[d] + i) % nc;
      if (gch < 0 && s_req[d][c]) gch = c;
    end
    eg = (gch >= 0) ? (32'd1 << gch) : 32'd0;
    chk(d == 0 ? "gnt_a" : "gnt_b", og, eg);
    sl = cyc % 4;
    erv = '0;
    eerr = '0;
    if (ev_v[d][sl]) begin
      erv = 32'd1 << ev_ch[d][sl];
      if (ev_err[d][sl]) eerr = erv;
      lastrd[d] = ev_d[d][sl];
      ev_v[d][sl] = 1'b0;
    end
    chk(d == 0 ? "rvalid_a" : "rvalid_b", orv, erv);
    chk(d == 0 ? "rerr_a" : "rerr_b", oerr, eerr);
    chk(d == 0 ? "rdata_a" : "rdata_b", ord, lastrd[d]);
    if (!rst && gch >= 0) begin
      ptr[d] = (gch + 1) % nc;
      a = s_addr[d][gch];
      if (s_wr[d][gch]) begin
        if (a < dep) begin
          for (int b = 0; b < nb; b++) begin
            if (s_wm[d][gch][b*8 +: 8] == 8'hFF)
              mm[d][a][b*8 +: 8] = s_wd[d][gch][b*8 +: 8];
          end
        end
      end else begin
        sl = (cyc + lat) % 4;
        ev_v[d][sl]   = 1'b1;
        ev_ch[d][sl]  = gch;
        ev_err[d][sl] = (a >= dep);
        ev_d[d][sl]   = (a >= dep) ? 32'd0 : (mm[d][a] & wmsk);
      end
    end
    o_gnt[d] = og;
    o_rv[d]  = orv;
    o_err[d] = oerr;
    o_rd[d]  = ord;
  endtask

  task automatic step();
    apply();
    @(negedge clk);
    cyc_check(0);
    cyc_check(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] rbyte();
    case ($urandom % 4)
      0: return 8'hFF;
      1: return 8'h00;
      2: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0;
      lastrd[d] = '0;
      for (int s = 0; s < 4; s++) ev_v[d][s] = 1'b0;
    end
    clr();
    apply();
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_rv", o_rv[0], 32'd0);
    chk("rst_rd", o_rd[0], 32'd0);
    chk("rst_rd_b", o_rd[1], 32'd0);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      clr();
      set_ch(0, 0, 1'b1, a, $urandom, 32'hFFFF_FFFF);
      if (a < 16) set_ch(1, a % 3, 1'b1, a, $urandom, 32'hFFFF);
      step();
    end
    rst = 1'b1;
    clr();
    step();
    rst = 1'b0;

    clr();
    set_ch(0, 0, 1'b0, 1, '0, '0);
    set_ch(0, 1, 1'b0, 2, '0, '0);
    step(); chk("rr0", o_gnt[0], 32'd1);
    step(); chk("rr1", o_gnt[0], 32'd2);
    step(); chk("rr2", o_gnt[0], 32'd1);
    step(); chk("rr3", o_gnt[0], 32'd2);

    clr(); set_ch(0, 0, 1'b1, 5, 32'h1122_3344, 32'hFFFF_FFFF); step();
    clr(); set_ch(0, 0, 1'b1, 5, 32'hA5A5_A5A5, 32'h00FF_00FF); step();
    clr(); set_ch(0, 1, 1'b0, 5, '0, '0); step();
    clr(); step();
    chk("mask_wr", o_rd[0], 32'h11A5_33A5);

    clr(); set_ch(0, 0, 1'b1, 5, 32'hFFFF_FFFF, 32'h7F7F_7FFF); step();
    clr(); set_ch(0, 0, 1'b0, 5, '0, '0); step();
    clr(); step();
    chk("partial", o_rd[0], 32'h11A5_33FF);
    chk("rv_ch0", o_rv[0], 32'd1);

    clr(); set_ch(0, 1, 1'b0, 1020, '0, '0); step();
    clr(); step();
    chk("oob_rd", o_rd[0], 32'd0);
    chk("oob_err", o_err[0], 32'd2);
    clr(); set_ch(0, 0, 1'b1, 1020, 32'hDEAD_BEEF, 32'hFFFF_FFFF); step();
    clr(); set_ch(0, 0, 1'b0, 5, '0, '0); step();
    clr(); step();
    chk("oob_wr", o_rd[0], 32'h11A5_33FF);
    chk("oob_noerr", o_err[0], 32'd0);

    clr(); set_ch(1, 1, 1'b0, 3, '0, '0); step();
    clr(); step(); chk("lat1", o_rv[1], 32'd0);
    step(); chk("lat2", o_rv[1], 32'd2);
    step(); chk("lat3", o_rv[1], 32'd0);

    clr(); set_ch(0, 0, 1'b0, 2, '0, '0); step();
    rst = 1'b1;
    clr(); step(); chk("rst_drop", o_rv[0], 32'd0);
    rst = 1'b0;
    step(); chk("rst_drop2", o_rv[0], 32'd0);
    set_ch(0, 0, 1'b0, 3, '0, '0);
    set_ch(0, 1, 1'b0, 4, '0, '0);
    step(); chk("rst_ptr", o_gnt[0], 32'd1);

    for (int n = 0; n < 600; n++) begin
      clr();
      rst = ($urandom % 64) == 0;
      for (int k = 0; k < 2; k++) begin
        if ($urandom % 3 != 0)
          set_ch(0, k, 1'($urandom % 2),
                 ($urandom % 8 == 0) ? 1000 + int'($urandom % 24)
                                     : int'($urandom % 32),
                 $urandom, {rbyte(), rbyte(), rbyte(), rbyte()});
      end
      for (int k = 0; k < 3; k++) begin
        if ($urandom % 3 != 0)
          set_ch(1, k, 1'($urandom % 2), int'($urandom % 16),
                 $urandom, {16'h0, rbyte(), rbyte()});
      end
      step();
    end
    rst = 1'b0;
    clr();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prim_ram_1p_arb.md
PRIM_RAM_1P_ARB -- requirements
Module: prim_ram_1p_arb

Interface
REQ-001 SHALL have parameter Width, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter Depth, default 2048, meaning number of words; Aw = $clog2(Depth).
REQ-003 SHALL have parameter DataBitsPerMask, default 8, meaning data bits per internal mask bit; Width divisible by it.
REQ-004 SHALL have parameter NumCh, default 2, meaning number of requester channels, range 1..8.
REQ-005 SHALL have parameter OutReg, default 0, meaning 1 adds a read output register stage.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req_i, input, NumCh, per-channel access request.
REQ-009 SHALL have port gnt_o, output, NumCh, per-channel grant, one-hot or zero.
REQ-010 SHALL have port write_i, input, NumCh, per-channel write (1) / read (0).
REQ-011 SHALL have port addr_i, input, NumCh*Aw, packed per-channel word addresses.
REQ-012 SHALL have port wdata_i, input, NumCh*Width, packed per-channel write data.
REQ-013 SHALL have port wmask_i, input, NumCh*Width, packed per-channel full bit mask.
REQ-014 SHALL have port rvalid_o, input-indexed output, NumCh, per-channel read-data-valid pulse.
REQ-015 SHALL have port rerr_o, output, NumCh, per-channel out-of-range flag, qualified by rvalid_o.
REQ-016 SHALL have port rdata_o, output, Width, shared read data, valid only with an rvalid_o bit.

Function
REQ-017 SHALL perform at most one memory access per cycle, for the granted channel only.
REQ-018 SHALL grant combinationally in the request cycle: gnt_o[k]=1 only if req_i[k]=1.
REQ-019 SHALL arbitrate round-robin: priority pointer p; first requesting channel from p upward, wrapping at NumCh.
REQ-020 SHALL set p to (k+1) mod NumCh after granting channel k; p unchanged when no grant.
REQ-021 SHALL hold ungranted requests' responsibility with the requester; block stores no pending request.
REQ-022 SHALL write mask byte i only when all DataBitsPerMask bits of that byte's wmask_i slice are 1.
REQ-023 SHALL return read data with latency 1+OutReg cycles after grant, rvalid_o pulsing one cycle on the granting channel.
REQ-024 SHALL sustain back-to-back reads (one per cycle, any channel mix); rvalid_o stays one-hot or zero.
REQ-025 SHALL drop writes with addr >= Depth; reads with addr >= Depth return rdata_o=0 with rerr_o=1.
REQ-026 SHALL give writes no rvalid_o; write then read same address next cycle returns new data.
REQ-027 SHALL hold rdata_o stable between reads; it changes only when a read completes.
REQ-028 SHALL with NumCh=1 reduce to a plain single-port RAM: gnt_o = req_i.

Reset
REQ-029 SHALL on rst_i clear p to 0, rvalid_o, rerr_o and rdata_o to 0 and the read pipeline.
REQ-030 SHALL drop in-flight reads on reset mid-operation; no rvalid_o for them after release.
REQ-031 SHALL not reset memory contents; gnt_o remains combinational from req_i during reset but no access occurs.

Structure
REQ-032 SHALL use a shared package prim_ram_arb_pkg holding MaxCh=8 and the channel index type.
REQ-033 SHALL contain one sub-module prim_rr_arb (NumCh-wide round-robin arbiter with pointer register).
REQ-034 SHALL keep the memory array writable by $readmemh backdoor (plain always, not always_ff).

Verification
REQ-035 SHALL test: NumCh=2, both req reads from reset -> ch0 granted cycle 0, ch1 cycle 1, alternating thereafter.
REQ-036 SHALL test: ch0 write addr 5 data 0xA5A5A5A5 mask 0x00FF00FF over 0x11223344 -> read returns 0x11A533A5.
REQ-037 SHALL test: OutReg=1, read at cycle 0 -> rvalid_o on that channel at cycle 2 exactly.
REQ-038 SHALL test: Depth=1000, read addr 1020 -> rdata_o=0, rerr_o=1; write addr 1020 leaves memory unchanged.
REQ-039 SHALL test: rst_i asserted one cycle after a read grant -> no rvalid_o ever for that read, p=0.
REQ-040 SHALL test: wmask byte 0x7F (partial) -> that byte not written.
